// File: rtl/bin2bcd_pkg.sv
// Shared types, default sizes and the leading-zero search for the
// binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEF  = 64;
  localparam int DIGITS_DEF = 20;
  localparam int CNTW_DEF   = 5;

  // Index of the most significant nonzero digit plus one; 1 for an all-zero value.
  function automatic logic [CNTW_DEF-1:0] digit_count(input logic [4*DIGITS_DEF-1:0] bcd);
    logic [CNTW_DEF-1:0] n;
    logic                found;
    n     = CNTW_DEF'(1);
    found = 1'b0;
    for (int k = DIGITS_DEF - 1; k >= 0; k--) begin
      if (!found && (bcd[4*k +: 4] != 4'd0)) begin
        n     = CNTW_DEF'(k + 1);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a requester and the BCD converter.
//
// Handshake: start is a request that the converter samples only while busy
// is low; a sampled start captures bin in the same cycle. There is no
// backpressure and requests made while busy is high are dropped, not queued.
// done is a single-cycle pulse marking bcd/ndigits as freshly updated; those
// two keep their value until the next done, so they may be read at any time.
// state mirrors the converter's FSM for observation.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 64,
  parameter int DIGITS = 20,
  parameter int CNTW   = 5
);
  import bin2bcd_pkg::*;

  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [CNTW-1:0]       ndigits;
  state_t                state;

  modport master (
    output start, bin,
    input  busy, done, bcd, ndigits, state
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, ndigits, state
  );

endinterface

// File: rtl/bin2bcd_seq_digit_adj.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more.
// Inputs never exceed 9, so the result tops out at 12 and fits in 4 bits.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Conditional +3 correction ahead of the left shift.
  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one 64-bit snapshot per accepted start,
// one bit per cycle, producing packed BCD plus a significant-digit count.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF,
  parameter int CNTW   = CNTW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  bin2bcd_seq_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  state_t                state;
  logic [WIDTH-1:0]      sh;
  logic [4*DIGITS-1:0]   acc;
  logic [CW-1:0]         cnt;
  logic [4*DIGITS-1:0]   bcd_r;
  logic [CNTW-1:0]       ndig_r;
  logic                  done_r;

  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS-1:0]   acc_next;
  logic [WIDTH-1:0]      sh_next;
  logic                  unused_adj_msb;

  // Every digit is corrected in parallel before the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // Shift {accumulator, shift register} left by one. The bit leaving the top
  // digit is always zero because the top digit never exceeds 1.
  assign acc_next       = {adj[4*DIGITS-2:0], sh[WIDTH-1]};
  assign sh_next        = {sh[WIDTH-2:0], 1'b0};
  assign unused_adj_msb = adj[4*DIGITS-1];

  // Conversion FSM; result registers only change on the edge entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      sh     <= '0;
      acc    <= '0;
      cnt    <= '0;
      bcd_r  <= '0;
      ndig_r <= CNTW'(1);
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            sh    <= bus.bin;
            acc   <= '0;
            cnt   <= CW'(WIDTH - 1);
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc <= acc_next;
          sh  <= sh_next;
          if (cnt == '0) begin
            bcd_r  <= acc_next;
            ndig_r <= digit_count(acc_next);
            done_r <= 1'b1;
            state  <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = (state != S_IDLE);
  assign bus.done    = done_r;
  assign bus.bcd     = bcd_r;
  assign bus.ndigits = ndig_r;
  assign bus.state   = state;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against a decimal reference model.
module tb_bin2bcd_seq;
  import bin2bcd_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  bin2bcd_seq_if #(.WIDTH(64), .DIGITS(20), .CNTW(5)) bus ();

  bin2bcd_seq #(.WIDTH(64), .DIGITS(20), .CNTW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: decimal digits by repeated division
  function automatic logic [79:0] ref_bcd(input logic [63:0] v);
    logic [79:0] r;
    logic [63:0] x;
    r = '0;
    x = v;
    for (int i = 0; i < 20; i++) begin
      r[4*i +: 4] = 4'(x % 64'd10);
      x = x / 64'd10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_nd(input logic [63:0] v);
    int          n;
    logic [63:0] x;
    n = 0;
    x = v;
    do begin
      n++;
      x = x / 64'd10;
    end while (x != 64'd0);
    return 5'(n);
  endfunction

  // Driver: one conversion with a single-cycle start pulse
  task automatic run_conv(input logic [63:0] v, output logic [79:0] r_bcd,
                          output logic [4:0] r_nd, output int busy_cyc,
                          output int done_cyc);
    r_bcd    = 'x;
    r_nd     = 'x;
    busy_cyc = 0;
    done_cyc = 0;
    @(negedge clk);
    bus.bin   = v;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.busy) break;
      busy_cyc++;
      if (bus.done) begin
        done_cyc++;
        r_bcd = bus.bcd;
        r_nd  = bus.ndigits;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.state !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b done=%b state=%0d, required 0 0 0", bus.busy, bus.done, bus.state);
    end
    n_tests++;
    if (bus.bcd !== 80'h0 || bus.ndigits !== 5'd1) begin
      n_fail++;
      $display("FAIL reset_result: bcd=%h nd=%0d, required 0 1", bus.bcd, bus.ndigits);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vector(input string name, input logic [63:0] v,
                             input logic [79:0] exp_bcd, input logic [4:0] exp_nd);
    logic [79:0] got_bcd;
    logic [4:0]  got_nd;
    int          bc, dc;
    run_conv(v, got_bcd, got_nd, bc, dc);
    n_tests++;
    if (dc !== 1 || got_bcd !== exp_bcd || got_nd !== exp_nd) begin
      n_fail++;
      $display("FAIL %s: done=%0d bcd=%h nd=%0d, required 1 %h %0d", name, dc, got_bcd, got_nd, exp_bcd, exp_nd);
    end
  endtask

  task automatic test_zero_timing();
    logic [79:0] got_bcd;
    logic [4:0]  got_nd;
    int          bc, dc;
    run_conv(64'd0, got_bcd, got_nd, bc, dc);
    n_tests++;
    if (bc !== 65) begin
      n_fail++;
      $display("FAIL busy_len: busy cycles=%0d, required 65", bc);
    end
    n_tests++;
    if (dc !== 1 || got_bcd !== 80'h0 || got_nd !== 5'd1) begin
      n_fail++;
      $display("FAIL zero: done=%0d bcd=%h nd=%0d, required 1 0 1", dc, got_bcd, got_nd);
    end
  endtask

  task automatic test_random();
    logic [63:0] v;
    for (int i = 0; i < 12; i++) begin
      case (i % 3)
        0: v = {$urandom, $urandom};
        1: v = 64'($urandom_range(0, 99999));
        default: v = {32'($urandom_range(0, 15)), $urandom};
      endcase
      test_vector("random", v, ref_bcd(v), ref_nd(v));
    end
  endtask

  task automatic test_ignore_start();
    logic [79:0] prior, got_bcd;
    logic [4:0]  got_nd;
    int          bc, dc, cyc;
    bit          hold_bad;
    test_vector("prior_7", 64'd7, ref_bcd(64'd7), ref_nd(64'd7));
    prior    = bus.bcd;
    hold_bad = 1'b0;
    dc       = 0;
    got_bcd  = 'x;
    got_nd   = 'x;
    @(negedge clk);
    bus.bin   = 64'd255;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = {$urandom, $urandom};
    cyc       = 1;
    while (bus.busy && cyc < 200) begin
      if (cyc == 10 || cyc == 40) begin
        bus.start = 1'b1;
        bus.bin   = 64'd9;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        dc++;
        got_bcd = bus.bcd;
        got_nd  = bus.ndigits;
      end else if (bus.bcd !== prior) begin
        hold_bad = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    n_tests++;
    if (hold_bad) begin
      n_fail++;
      $display("FAIL hold: bcd changed before done, required %h throughout", prior);
    end
    n_tests++;
    if (dc !== 1 || got_bcd !== 80'h255 || got_nd !== 5'd3) begin
      n_fail++;
      $display("FAIL ignore_start: done=%0d bcd=%h nd=%0d, required 1 255 3", dc, got_bcd, got_nd);
    end
    bc = 0;
    repeat (6) begin
      if (bus.busy) bc++;
      @(negedge clk);
    end
    n_tests++;
    if (bc !== 0) begin
      n_fail++;
      $display("FAIL not_queued: busy cycles after done=%0d, required 0", bc);
    end
  endtask

  task automatic test_reset_mid();
    logic [79:0] got_bcd;
    logic [4:0]  got_nd;
    int          bc, dc;
    @(negedge clk);
    bus.bin   = 64'd12345;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (29) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.bcd !== 80'h0 || bus.ndigits !== 5'd1) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b bcd=%h nd=%0d, required 0 0 1", bus.busy, bus.bcd, bus.ndigits);
    end
    dc = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) dc++;
    end
    rst_n = 1'b1;
    repeat (70) begin
      @(negedge clk);
      if (bus.done || bus.busy) dc++;
    end
    n_tests++;
    if (dc !== 0) begin
      n_fail++;
      $display("FAIL reset_abort: done/busy seen %0d times, required 0", dc);
    end
    run_conv(64'd99, got_bcd, got_nd, bc, dc);
    n_tests++;
    if (dc !== 1 || got_bcd !== 80'h99 || got_nd !== 5'd2) begin
      n_fail++;
      $display("FAIL after_reset: done=%0d bcd=%h nd=%0d, required 1 99 2", dc, got_bcd, got_nd);
    end
  endtask

  task automatic test_back_to_back();
    logic [79:0] exp_q[$];
    logic [4:0]  exp_nd_q[$];
    logic [63:0] v;
    int          seen, last_done, cyc;
    seen      = 0;
    last_done = -1;
    @(negedge clk);
    v = {$urandom, $urandom};
    exp_q.push_back(ref_bcd(v));
    exp_nd_q.push_back(ref_nd(v));
    bus.bin   = v;
    bus.start = 1'b1;
    for (cyc = 0; cyc < 400 && seen < 3; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: unexpected done, required none");
        end else if (bus.bcd !== exp_q[0] || bus.ndigits !== exp_nd_q[0]) begin
          n_fail++;
          $display("FAIL b2b_result: bcd=%h nd=%0d, required %h %0d", bus.bcd, bus.ndigits, exp_q[0], exp_nd_q[0]);
        end
        if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          void'(exp_nd_q.pop_front());
        end
        if (last_done >= 0) begin
          n_tests++;
          if (cyc - last_done !== 66) begin
            n_fail++;
            $display("FAIL b2b_period: %0d cycles, required 66", cyc - last_done);
          end
        end
        last_done = cyc;
        seen++;
        if (seen < 3) begin
          v = 64'($urandom_range(0, 1000000)) * 64'($urandom);
          exp_q.push_back(ref_bcd(v));
          exp_nd_q.push_back(ref_nd(v));
          bus.bin = v;
        end else begin
          bus.start = 1'b0;
        end
      end else if (bus.busy) begin
        bus.bin = {$urandom, $urandom};
      end
    end
    bus.start = 1'b0;
    n_tests++;
    if (seen !== 3) begin
      n_fail++;
      $display("FAIL b2b_count: %0d conversions, required 3", seen);
    end
    repeat (3) @(negedge clk);
  endtask

  // Sequence and report
  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_zero_timing();
    test_vector("vec_7021292621", 64'h1A2806C4D, {40'h0, 40'h7021292621}, 5'd10);
    test_vector("vec_14digit", 64'd26375397569930, 80'h26375397569930, 5'd14);
    test_vector("vec_max", 64'hFFFFFFFFFFFFFFFF, 80'h18446744073709551615, 5'd20);
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
